// File: rtl/cpu_pkg.sv
// Shared definitions for the PC sequencing logic: branch condition codes,
// flag bit positions within the {V,N,Z} flag vector, and sequencer states.
package cpu_pkg;

  localparam logic [2:0] COND_NE     = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_GT     = 3'b010;
  localparam logic [2:0] COND_LT     = 3'b011;
  localparam logic [2:0] COND_GE     = 3'b100;
  localparam logic [2:0] COND_LE     = 3'b101;
  localparam logic [2:0] COND_OV     = 3'b110;
  localparam logic [2:0] COND_UNCOND = 3'b111;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } seq_state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Evaluates a 3-bit branch condition code against the registered flags.
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       cond_true
);

  logic flag_z;
  logic flag_n;
  logic flag_v;

  assign flag_z = flags[FLAG_Z];
  assign flag_n = flags[FLAG_N];
  assign flag_v = flags[FLAG_V];

  // Condition decode: one boolean per code.
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_NE:     cond_true = ~flag_z;
      COND_EQ:     cond_true = flag_z;
      COND_GT:     cond_true = ~flag_z & ~flag_n;
      COND_LT:     cond_true = flag_n;
      COND_GE:     cond_true = flag_z | ~flag_n;
      COND_LE:     cond_true = flag_z | flag_n;
      COND_OV:     cond_true = flag_v;
      COND_UNCOND: cond_true = 1'b1;
      default:     cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Program counter sequencer: sequential stepping, PC-relative (B) and
// register (BR) branches, flag register and a sticky HALT state.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_RUN  | normal stepping; branches, flag writes and HLT are honoured
// ST_HALT | pc and flags frozen, taken forced low; only rst leaves it
module pc_seq_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              IMM_W    = 9,
  parameter int              PC_INC   = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [2:0]       flag_we,
  input  logic [2:0]       flag_in,
  input  logic             br_valid,
  input  logic             br_reg,
  input  logic [2:0]       cond,
  input  logic [IMM_W-1:0] imm,
  input  logic [PC_W-1:0]  rs,
  input  logic             halt_in,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_seq,
  output logic             taken,
  output logic             halted,
  output logic [2:0]       flags
);

  seq_state_t      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [2:0]      flags_q, flags_d;
  logic            cond_true;
  logic [PC_W-1:0] imm_off;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] target;

  branch_cond_eval u_cond (
    .cond      (cond),
    .flags     (flags_q),
    .cond_true (cond_true)
  );

  // Word offset sign-extended and scaled to bytes in one concatenation.
  assign imm_off   = {{(PC_W-IMM_W-1){imm[IMM_W-1]}}, imm, 1'b0};
  assign pc_seq    = pc_q + PC_W'(PC_INC);
  assign br_target = pc_seq + imm_off;
  assign target    = br_reg ? rs : br_target;

  // Flags feeding the condition are the registered ones, so a same-cycle
  // flag write cannot influence this cycle's branch decision.
  assign taken  = br_valid & cond_true & (state_q == ST_RUN);
  assign pc     = pc_q;
  assign flags  = flags_q;
  assign halted = (state_q == ST_HALT);

  // Next-state, next-pc and flag update; stall freezes everything in RUN.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    case (state_q)
      ST_RUN: begin
        if (!stall) begin
          flags_d = (flags_q & ~flag_we) | (flag_in & flag_we);
          if (halt_in) begin
            state_d = ST_HALT;
          end else if (taken) begin
            pc_d = target;
          end else begin
            pc_d = pc_seq;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State registers with synchronous reset overriding stall and HALT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      flags_q <= 3'b000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed scenarios followed by randomized cycles, all checked against a
// behavioural model of the sequencer held in plain integers.
module tb_pc_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [2:0]  flag_we;
  logic [2:0]  flag_in;
  logic        br_valid;
  logic        br_reg;
  logic [2:0]  cond;
  logic [8:0]  imm;
  logic [15:0] rs;
  logic        halt_in;
  logic [15:0] pc;
  logic [15:0] pc_seq;
  logic        taken;
  logic        halted;
  logic [2:0]  flags;

  int n_pass  = 0;
  int n_total = 0;

  int       m_pc;
  bit [2:0] m_flags;
  bit       m_halted;

  pc_seq_unit dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .flag_we  (flag_we),
    .flag_in  (flag_in),
    .br_valid (br_valid),
    .br_reg   (br_reg),
    .cond     (cond),
    .imm      (imm),
    .rs       (rs),
    .halt_in  (halt_in),
    .pc       (pc),
    .pc_seq   (pc_seq),
    .taken    (taken),
    .halted   (halted),
    .flags    (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  function automatic bit cond_ok(input bit [2:0] c, input bit [2:0] f);
    bit z, n, v;
    z = f[0];
    n = f[1];
    v = f[2];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return z || n;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic idle();
    rst = 0; stall = 0; flag_we = 0; flag_in = 0; br_valid = 0; br_reg = 0;
    cond = 0; imm = 0; rs = 0; halt_in = 0;
  endtask

  // One clock: check combinational outputs, advance model, check registers.
  task automatic tick(input string tag);
    bit exp_taken;
    int simm;
    int nxt;
    #3;
    exp_taken = br_valid && !m_halted && cond_ok(cond, m_flags);
    chk({tag, ".taken"}, {31'b0, taken}, {31'b0, exp_taken});
    chk({tag, ".pc_seq"}, {16'b0, pc_seq}, (m_pc + 2) % 65536);
    @(posedge clk);
    if (rst) begin
      m_pc = 0; m_flags = 0; m_halted = 0;
    end else if (!m_halted && !stall) begin
      for (int i = 0; i < 3; i++)
        if (flag_we[i]) m_flags[i] = flag_in[i];
      simm = int'(imm);
      if (imm[8]) simm = simm - 512;
      if (br_reg) nxt = int'(rs);
      else        nxt = m_pc + 2 + 2 * simm;
      if (halt_in)        m_halted = 1;
      else if (exp_taken) m_pc = ((nxt % 65536) + 65536) % 65536;
      else                m_pc = (m_pc + 2) % 65536;
    end
    #1;
    chk({tag, ".pc"}, {16'b0, pc}, m_pc);
    chk({tag, ".flags"}, {29'b0, flags}, {29'b0, m_flags});
    chk({tag, ".halted"}, {31'b0, halted}, {31'b0, m_halted});
  endtask

  initial begin
    m_pc = 0; m_flags = 0; m_halted = 0;
    idle();
    rst = 1;
    tick("reset0");
    tick("reset1");
    chk("reset_pc", {16'b0, pc}, 32'h0000);
    chk("reset_flags", {29'b0, flags}, 32'h0);
    idle();

    // Sequential stepping 0, 2, 4.
    tick("step1");
    chk("step_pc2", {16'b0, pc}, 32'h0002);
    tick("step2");
    chk("step_pc4", {16'b0, pc}, 32'h0004);
    tick("step3");
    tick("step4");
    // At pc 0x0008: write Z = 1.
    flag_we = 3'b001; flag_in = 3'b001;
    tick("setz");
    idle();
    while (m_pc != 16'h0010) tick("to10");
    // B EQ, imm = -3 at pc 0x0010 -> 0x000C.
    br_valid = 1; cond = 3'b001; imm = 9'h1FD;
    tick("b_eq");
    chk("b_eq_pc", {16'b0, pc}, 32'h000C);
    // Get to 0x0040 then BR unconditional to 0xBEEE.
    br_reg = 1; cond = 3'b111; rs = 16'h0040;
    tick("br40");
    rs = 16'hBEEE;
    #3;
    chk("br_taken", {31'b0, taken}, 32'h1);
    tick("br_beee");
    chk("br_pc", {16'b0, pc}, 32'hBEEE);
    idle();

    // Same-cycle flag hazard: clear flags, then Z write plus NE branch.
    flag_we = 3'b111; flag_in = 3'b000;
    tick("clrf");
    flag_we = 3'b001; flag_in = 3'b001;
    br_valid = 1; br_reg = 1; cond = 3'b000; rs = 16'h1234;
    tick("hazard");
    chk("hazard_pc", {16'b0, pc}, 32'h1234);
    chk("hazard_flags", {29'b0, flags}, 32'h1);
    idle();

    // Wrap: BR to 0xFFFE, then step.
    br_valid = 1; br_reg = 1; cond = 3'b111; rs = 16'hFFFE;
    tick("to_fffe");
    idle();
    tick("wrap");
    chk("wrap_pc", {16'b0, pc}, 32'h0000);

    // Stall over halt, then halt with a taken branch presented.
    stall = 1; halt_in = 1;
    tick("stall_halt");
    chk("stall_halt_pc", {16'b0, pc}, 32'h0000);
    chk("stall_halt_h", {31'b0, halted}, 32'h0);
    stall = 0; halt_in = 1; br_valid = 1; br_reg = 1; cond = 3'b111; rs = 16'h5550;
    tick("halt_enter");
    chk("halt_h", {31'b0, halted}, 32'h1);
    chk("halt_pc", {16'b0, pc}, 32'h0000);
    halt_in = 0; flag_we = 3'b111; flag_in = 3'b110;
    tick("halted_br");
    #3;
    chk("halted_taken", {31'b0, taken}, 32'h0);
    tick("halted_br2");
    idle();

    // Reset in HALT, also while stalled.
    rst = 1; stall = 1;
    tick("rst_halt");
    chk("rst_halt_pc", {16'b0, pc}, 32'h0000);
    chk("rst_halt_h", {31'b0, halted}, 32'h0);
    chk("rst_halt_f", {29'b0, flags}, 32'h0);
    idle();
    #3;
    chk("post_rst_ne", {31'b0, cond_ok(3'b000, 3'b000) ? taken : 1'b1}, 32'h0);

    // Randomized phase.
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 99) < 4);
      stall    = ($urandom_range(0, 99) < 20);
      halt_in  = ($urandom_range(0, 99) < 4);
      flag_we  = 3'($urandom);
      flag_in  = 3'($urandom);
      br_valid = ($urandom_range(0, 99) < 50);
      br_reg   = 1'($urandom);
      cond     = 3'($urandom);
      imm      = 9'($urandom);
      rs       = 16'($urandom);
      tick("rand");
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
